// File: rtl/sram_like_bridge_pkg.sv
// Shared types for the SRAM-like bridge: FSM states, transfer-size codes,
// and the mapping from byte-write-enable patterns to bus_size.
package sram_like_pkg;

    localparam int SIZE_W = 3;

    localparam logic [SIZE_W-1:0] SIZE_B   = 3'd0;
    localparam logic [SIZE_W-1:0] SIZE_H   = 3'd1;
    localparam logic [SIZE_W-1:0] SIZE_W32 = 3'd2;
    localparam logic [SIZE_W-1:0] SIZE_D   = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Contiguous 1/2/4/8-lane masks map to their log2 size; zero (a read)
    // or any malformed mask falls back to the full bus width.
    function automatic logic [SIZE_W-1:0] wen_to_size(input logic [7:0] wen,
                                                       input logic [SIZE_W-1:0] full_size);
        logic [3:0] cnt;
        logic [3:0] lo;
        logic [7:0] norm;
        logic [SIZE_W-1:0] size;
        cnt = 4'd0;
        lo  = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (wen[i]) begin
                cnt = cnt + 4'd1;
                lo  = i[3:0];
            end
        end
        norm = wen >> lo;
        size = full_size;
        case (cnt)
            4'd1: if (norm == 8'h01) size = SIZE_B;
            4'd2: if (norm == 8'h03) size = SIZE_H;
            4'd4: if (norm == 8'h0F) size = SIZE_W32;
            4'd8: if (norm == 8'hFF) size = SIZE_D;
            default: size = full_size;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sram_like_bridge.sv
// Single-cycle CPU SRAM port to SRAM-like req/addr_ok/data_ok bus; stalls the
// CPU until data_ok and holds read data while another stall source freezes the pipe.
module sram_like_bridge
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_en_i,
    input  logic [DATA_W/8-1:0] cpu_wen_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_stall_o,
    input  logic                cpu_hold_i,
    output logic                bus_req_o,
    output logic                bus_wr_o,
    output logic [SIZE_W-1:0]   bus_size_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_addr_ok_i,
    input  logic                bus_data_ok_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [SIZE_W-1:0] FULL_SIZE = (BYTES == 8) ? SIZE_D : SIZE_W32;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        wen8;
    logic              resp_done;

    assign resp_done = (state_q == RESP) && bus_data_ok_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cpu_en_i) state_d = bus_addr_ok_i ? RESP : REQ;
            REQ:  if (bus_addr_ok_i) state_d = RESP;
            RESP: if (bus_data_ok_i) state_d = cpu_hold_i ? DONE : IDLE;
            DONE: if (!cpu_hold_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wen8             = '0;
        wen8[BYTES-1:0]  = cpu_wen_i;
        rdata_d          = resp_done ? bus_rdata_i : rdata_q;
        // Gate with rst so a held cpu_en cannot leak a request during reset.
        bus_req_o        = !rst_i && (((state_q == IDLE) && cpu_en_i) || (state_q == REQ));
        cpu_stall_o      = !rst_i && cpu_en_i && (state_q != DONE) && !resp_done;
        cpu_rdata_o      = resp_done ? bus_rdata_i : rdata_q;
        bus_wr_o         = |cpu_wen_i;
        bus_size_o       = wen_to_size(wen8, FULL_SIZE);
        bus_addr_o       = cpu_addr_i;
        bus_wdata_o      = cpu_wdata_i;
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge (32-bit and 64-bit instances) with a read-data scoreboard.
module tb_sram_like_bridge;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en = 1'b0, hold = 1'b0, addr_ok = 1'b0, data_ok = 1'b0;
    logic [3:0]  wen = '0;
    logic [31:0] addr = '0, wdata = '0, brdata = '0;
    logic [31:0] rdata, baddr, bwdata;
    logic        stall, req, wr;
    logic [2:0]  size;

    logic [7:0]  wen64 = '0;
    logic [63:0] rdata64, bwdata64;
    logic [31:0] baddr64;
    logic        stall64, req64, wr64;
    logic [2:0]  size64;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    int req_cnt, stall_cnt;

    always #5 clk = ~clk;

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .cpu_en_i(en), .cpu_wen_i(wen), .cpu_addr_i(addr),
        .cpu_wdata_i(wdata), .cpu_rdata_o(rdata), .cpu_stall_o(stall), .cpu_hold_i(hold),
        .bus_req_o(req), .bus_wr_o(wr), .bus_size_o(size), .bus_addr_o(baddr),
        .bus_wdata_o(bwdata), .bus_addr_ok_i(addr_ok), .bus_data_ok_i(data_ok),
        .bus_rdata_i(brdata)
    );

    sram_like_bridge #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .cpu_en_i(1'b0), .cpu_wen_i(wen64), .cpu_addr_i(32'h0),
        .cpu_wdata_i(64'h0), .cpu_rdata_o(rdata64), .cpu_stall_o(stall64), .cpu_hold_i(1'b0),
        .bus_req_o(req64), .bus_wr_o(wr64), .bus_size_o(size64), .bus_addr_o(baddr64),
        .bus_wdata_o(bwdata64), .bus_addr_ok_i(1'b0), .bus_data_ok_i(1'b0),
        .bus_rdata_i(64'h0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the next expected read word and compares it with cpu_rdata.
    task automatic chk_sb(input string tag);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            chk(tag, 64'(rdata), 64'(exp));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Reset with cpu_en asserted: outputs must stay quiet.
        en = 1'b1;
        #2;
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_state", 64'(dut32.state_q), 64'(IDLE));
        en = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Read, fast slave.
        cyc();
        en = 1'b1; wen = 4'b0000; addr = 32'hBFC00000; addr_ok = 1'b1;
        sb.push_back(32'h3C1D0000);
        settle();
        chk("rd_req", 64'(req), 64'd1);
        chk("rd_stall0", 64'(stall), 64'd1);
        chk("rd_size", 64'(size), 64'd2);
        chk("rd_wr", 64'(wr), 64'd0);
        chk("rd_addr", 64'(baddr), 64'hBFC00000);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h3C1D0000;
        settle();
        chk("rd_req_resp", 64'(req), 64'd0);
        chk("rd_stall1", 64'(stall), 64'd0);
        chk_sb("rd_data");
        cyc();
        en = 1'b0; data_ok = 1'b0; brdata = 32'h0;
        settle();
        chk("rd_idle", 64'(dut32.state_q), 64'(IDLE));
        chk("rd_hold_q", 64'(rdata), 64'h3C1D0000);

        // Write, slow slave, with stray data_ok in REQ and stray addr_ok in RESP.
        req_cnt = 0; stall_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            en = 1'b1; wen = 4'b0011; addr = 32'h80001002; wdata = 32'h0000ABCD;
            addr_ok = (k == 3) || (k == 5);
            data_ok = (k == 1) || (k == 6);
            brdata  = (k == 1) ? 32'hBAD0BAD0 : 32'h0;
            settle();
            req_cnt   += int'(req);
            stall_cnt += int'(stall);
            if (k == 0) begin
                chk("wr_wr", 64'(wr), 64'd1);
                chk("wr_size", 64'(size), 64'd1);
                chk("wr_addr", 64'(baddr), 64'h80001002);
                chk("wr_wdata", 64'(bwdata), 64'h0000ABCD);
            end
            if (k == 1) chk("wr_dok_in_req", 64'(stall), 64'd1);
            if (k == 5) chk("wr_aok_in_resp", 64'(dut32.state_q), 64'(RESP));
        end
        chk("wr_req_cycles", 64'(req_cnt), 64'd4);
        chk("wr_stall_cycles", 64'(stall_cnt), 64'd6);
        cyc();
        en = 1'b0; wen = 4'b0000; addr_ok = 1'b0; data_ok = 1'b0;
        settle();
        chk("wr_idle", 64'(dut32.state_q), 64'(IDLE));

        // Held response.
        cyc();
        en = 1'b1; addr = 32'h00000040; addr_ok = 1'b1;
        sb.push_back(32'hDEADBEEF);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'hDEADBEEF; hold = 1'b1;
        settle();
        chk("hd_stall", 64'(stall), 64'd0);
        chk_sb("hd_data");
        for (int k = 0; k < 5; k++) begin
            cyc();
            data_ok = 1'b0; brdata = 32'h12345678;
            hold = (k < 4);
            settle();
            chk("hd_state", 64'(dut32.state_q), 64'(DONE));
            chk("hd_stall_held", 64'(stall), 64'd0);
            chk("hd_req", 64'(req), 64'd0);
            chk("hd_rdata", 64'(rdata), 64'hDEADBEEF);
        end
        cyc();
        en = 1'b0;
        settle();
        chk("hd_idle", 64'(dut32.state_q), 64'(IDLE));

        // Back-to-back reads.
        cyc();
        en = 1'b1; addr = 32'h00001000; addr_ok = 1'b1;
        sb.push_back(32'h11111111);
        sb.push_back(32'h22222222);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h11111111;
        settle();
        chk_sb("b2b_data1");
        cyc();
        addr = 32'h00001004; addr_ok = 1'b1; data_ok = 1'b0; brdata = 32'h0;
        settle();
        chk("b2b_req2", 64'(req), 64'd1);
        chk("b2b_state2", 64'(dut32.state_q), 64'(IDLE));
        chk("b2b_addr2", 64'(baddr), 64'h00001004);
        cyc();
        addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h22222222;
        settle();
        chk_sb("b2b_data2");
        cyc();
        en = 1'b0; data_ok = 1'b0; brdata = 32'h0;

        // Reset in RESP.
        cyc();
        en = 1'b1; addr = 32'h00002000; addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        settle();
        chk("rs_pre_state", 64'(dut32.state_q), 64'(RESP));
        chk("rs_pre_rdata", 64'(rdata), 64'h22222222);
        rst = 1'b1;
        #1;
        chk("rs_state", 64'(dut32.state_q), 64'(IDLE));
        chk("rs_stall", 64'(stall), 64'd0);
        chk("rs_req", 64'(req), 64'd0);
        chk("rs_rdata", 64'(rdata), 64'd0);
        en = 1'b0;
        cyc();
        rst = 1'b0;

        // Size encoding, both widths.
        wen = 4'b1111; #1; chk("sz32_word", 64'(size), 64'd2);
        wen = 4'b0100; #1; chk("sz32_byte", 64'(size), 64'd0);
        wen = 4'b0101; #1; chk("sz32_bad", 64'(size), 64'd2);
        wen = 4'b0000;
        wen64 = 8'h00; #1; chk("sz64_read", 64'(size64), 64'd3);
        wen64 = 8'hF0; #1; chk("sz64_f0", 64'(size64), 64'd2);
        wen64 = 8'h01; #1; chk("sz64_01", 64'(size64), 64'd0);
        wen64 = 8'h05; #1; chk("sz64_bad", 64'(size64), 64'd3);
        wen64 = 8'hFF; #1; chk("sz64_ff", 64'(size64), 64'd3);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
